// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter: count direction and bound-handling mode.
package counter_pkg;

  localparam bit DIR_UP        = 1'b1;
  localparam bit DIR_DOWN      = 1'b0;

  localparam bit MODE_WRAP     = 1'b0;
  localparam bit MODE_SATURATE = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// Divides enabled cycles by PRESCALE: tick_o is high on every PRESCALE-th enabled cycle.
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic enable_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] phase_q;

  // A restart cycle never ticks; the phase starts over from 0 instead.
  assign tick_o = enable_i && !restart_i && (phase_q == LAST);

  always_ff @(posedge clock_i) begin
    if (reset_i || restart_i) begin
      phase_q <= '0;
    end else if (enable_i) begin
      phase_q <= tick_o ? '0 : phase_q + CW'(1);
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Prescaled up/down counter with a programmable top value, wrap or saturate at the
// bounds, a one-cycle terminal pulse and a sticky overflow flag.
module updown_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH     = 8,
  parameter longint MAX_VALUE = (longint'(1) << WIDTH) - 1,
  parameter int     PRESCALE  = 1,
  parameter bit     SATURATE  = MODE_WRAP
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             up_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] counter_value_o,
  output logic             terminal_o,
  output logic             overflow_o
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter: WIDTH %0d outside 2..32", WIDTH);
  end
  if (MAX_VALUE < 1 || MAX_VALUE > (longint'(1) << WIDTH) - 1) begin : g_bad_max
    $error("updown_counter: MAX_VALUE %0d outside 1..2**WIDTH-1", MAX_VALUE);
  end
  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
    $error("updown_counter: PRESCALE %0d outside 1..256", PRESCALE);
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] count_q;
  logic             terminal_q;
  logic             overflow_q;
  logic             tick;
  logic             at_top;
  logic             at_bottom;

  // Clear and load both discard any partial prescale.
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .enable_i  (enable_i),
    .restart_i (clear_i || load_i),
    .tick_o    (tick)
  );

  assign at_top    = (count_q == MAX_V);
  assign at_bottom = (count_q == '0);

  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      count_q    <= '0;
      terminal_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (load_i) begin
      count_q    <= (load_value_i > MAX_V) ? MAX_V : load_value_i;
      terminal_q <= 1'b0;
    end else begin
      terminal_q <= 1'b0;
      if (tick) begin
        if (up_i == DIR_UP) begin
          if (at_top) begin
            terminal_q <= 1'b1;
            overflow_q <= 1'b1;
            if (SATURATE == MODE_WRAP) count_q <= '0;
          end else begin
            count_q <= count_q + WIDTH'(1);
          end
        end else begin
          if (at_bottom) begin
            terminal_q <= 1'b1;
            overflow_q <= 1'b1;
            if (SATURATE == MODE_WRAP) count_q <= MAX_V;
          end else begin
            count_q <= count_q - WIDTH'(1);
          end
        end
      end
    end
  end

  assign counter_value_o = count_q;
  assign terminal_o      = terminal_q;
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: three configurations share one stimulus stream and are
// compared every cycle against an arithmetic reference model, plus directed checks.
module tb_updown_counter;
  import counter_pkg::*;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       up;
  logic       clear;
  logic       load;
  logic [3:0] load_value;

  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic       term_a, term_b, term_c;
  logic       ovf_a, ovf_b, ovf_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cnt;
    int since;  // enabled cycles since the last reset/clear/load
    bit term;
    bit ovf;
  } mdl_t;

  mdl_t ma, mb, mc;

  // A: wrap, no prescale.  B: saturate, no prescale.  C: wrap, prescale 3.
  updown_counter #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(1), .SATURATE(MODE_WRAP)) dut_a (
    .clock_i(clk), .reset_i(rst), .enable_i(enable), .up_i(up), .clear_i(clear),
    .load_i(load), .load_value_i(load_value),
    .counter_value_o(cnt_a), .terminal_o(term_a), .overflow_o(ovf_a));

  updown_counter #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(1), .SATURATE(MODE_SATURATE)) dut_b (
    .clock_i(clk), .reset_i(rst), .enable_i(enable), .up_i(up), .clear_i(clear),
    .load_i(load), .load_value_i(load_value),
    .counter_value_o(cnt_b), .terminal_o(term_b), .overflow_o(ovf_b));

  updown_counter #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(3), .SATURATE(MODE_WRAP)) dut_c (
    .clock_i(clk), .reset_i(rst), .enable_i(enable), .up_i(up), .clear_i(clear),
    .load_i(load), .load_value_i(load_value),
    .counter_value_o(cnt_c), .terminal_o(term_c), .overflow_o(ovf_c));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mdl_t mdl_next(mdl_t m, int maxv, int ps, bit sat,
                                    bit r, bit c, bit l, int lv, bit e, bit u);
    mdl_t n;
    n = m;
    n.term = 1'b0;
    if (r || c) begin
      n.cnt = 0; n.since = 0; n.ovf = 1'b0;
    end else if (l) begin
      n.cnt = (lv > maxv) ? maxv : lv;
      n.since = 0;
    end else if (e) begin
      n.since = m.since + 1;
      if (n.since % ps == 0) begin
        if (u && m.cnt < maxv)       n.cnt = m.cnt + 1;
        else if (!u && m.cnt > 0)    n.cnt = m.cnt - 1;
        else begin
          n.term = 1'b1;
          n.ovf  = 1'b1;
          if (!sat) n.cnt = u ? 0 : maxv;
        end
      end
    end
    return n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_models();
    chk("a_cnt", {28'd0, cnt_a}, ma.cnt); chk("a_term", term_a, ma.term); chk("a_ovf", ovf_a, ma.ovf);
    chk("b_cnt", {28'd0, cnt_b}, mb.cnt); chk("b_term", term_b, mb.term); chk("b_ovf", ovf_b, mb.ovf);
    chk("c_cnt", {28'd0, cnt_c}, mc.cnt); chk("c_term", term_c, mc.term); chk("c_ovf", ovf_c, mc.ovf);
    chk("a_bound", cnt_a <= 4'd9, 1); chk("b_bound", cnt_b <= 4'd9, 1); chk("c_bound", cnt_c <= 4'd9, 1);
  endtask

  // Driver: apply one cycle of inputs, advance the models, check after the edge.
  task automatic cyc(bit e, bit u, bit c = 0, bit l = 0, int lv = 0, bit r = 0);
    enable = e; up = u; clear = c; load = l; load_value = 4'(lv); rst = r;
    @(posedge clk);
    ma = mdl_next(ma, 9, 1, 1'b0, r, c, l, lv, e, u);
    mb = mdl_next(mb, 9, 1, 1'b1, r, c, l, lv, e, u);
    mc = mdl_next(mc, 9, 3, 1'b0, r, c, l, lv, e, u);
    #1;
    cmp_models();
  endtask

  initial begin
    bit e, u, c, l, r;
    int lv;
    ma = '{0, 0, 1'b0, 1'b0}; mb = ma; mc = ma;
    rst = 1'b1; enable = 1'b0; up = DIR_UP; clear = 1'b0; load = 1'b0; load_value = '0;

    // Reset state
    cyc(1, DIR_UP, 0, 0, 0, 1);
    cyc(0, DIR_UP, 0, 0, 0, 1);
    chk("rst_cnt", {28'd0, cnt_a}, 0); chk("rst_term", term_a, 0); chk("rst_ovf", ovf_a, 0);

    // Up-count 10 steps with wrap: 1..9 then 0, one terminal pulse
    for (int i = 1; i <= 10; i++) begin
      cyc(1, DIR_UP);
      chk("wrap_cnt", {28'd0, cnt_a}, i % 10);
      chk("wrap_term", term_a, i == 10);
      chk("wrap_ovf", ovf_a, i == 10);
    end
    cyc(0, DIR_UP);
    chk("wrap_ovf_sticky", ovf_a, 1); chk("wrap_term_done", term_a, 0);

    // Saturating down-count from 1: 0, 0, 0 with two terminal pulses
    cyc(0, DIR_DOWN, 1);
    cyc(0, DIR_DOWN, 0, 1, 1);
    for (int i = 1; i <= 3; i++) begin
      cyc(1, DIR_DOWN);
      chk("sat_cnt", {28'd0, cnt_b}, 0);
      chk("sat_term", term_b, i >= 2);
    end
    chk("sat_ovf", ovf_b, 1);

    // Prescale 3: 7 enabled cycles among 4 disabled, steps on enabled cycles 3 and 6
    cyc(0, DIR_UP, 1);
    begin
      bit pat [11] = '{1, 0, 1, 1, 0, 0, 1, 1, 0, 1, 1};
      int n_en = 0;
      foreach (pat[k]) begin
        cyc(pat[k], DIR_UP);
        if (pat[k]) n_en++;
        chk("pre_cnt", {28'd0, cnt_c}, n_en / 3);
      end
    end
    chk("pre_final", {28'd0, cnt_c}, 2);

    // Load clamp and clear-over-load
    cyc(0, DIR_UP, 0, 1, 12);
    chk("load_clamp", {28'd0, cnt_a}, 9); chk("load_no_term", term_a, 0);
    cyc(0, DIR_UP, 1, 1, 5);
    chk("clear_over_load", {28'd0, cnt_a}, 0);

    // Reset mid-prescale: count 7, prescaler at 1, reset, next step after 3 enables
    repeat (21) cyc(1, DIR_UP);
    chk("mid_cnt", {28'd0, cnt_c}, 7);
    cyc(1, DIR_UP);
    cyc(1, DIR_UP, 0, 0, 0, 1);
    chk("mid_rst", {28'd0, cnt_c}, 0);
    cyc(1, DIR_UP); cyc(1, DIR_UP);
    chk("mid_no_step", {28'd0, cnt_c}, 0);
    cyc(1, DIR_UP);
    chk("mid_step", {28'd0, cnt_c}, 1);

    // Clear coincident with an up step at MAX_VALUE
    cyc(0, DIR_UP, 0, 1, 9);
    cyc(1, DIR_UP, 1);
    chk("clr_bound_cnt", {28'd0, cnt_a}, 0);
    chk("clr_bound_term", term_a, 0); chk("clr_bound_ovf", ovf_a, 0);

    // Randomized traffic against the model
    u = DIR_UP;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) u = ~u;
      e  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 59) == 0);
      c  = ($urandom_range(0, 39) == 0);
      l  = ($urandom_range(0, 24) == 0);
      lv = $urandom_range(0, 15);
      cyc(e, u, c, l, lv, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
